// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types, pipeline controller states and latch-control encodings.
package cpu_types_pkg;
    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} ctrl_state_t;
    localparam int DRAIN_CYCLES_DEF = 2;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES_DEF + 1);
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exm_en;
        logic mwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exm_flush;
        logic mwb_flush;
    } ctrl_t;
    // Flush beats enable inside a latch, so enables under a flush are don't-care (left at 1).
    localparam ctrl_t CTL_RUN    = 9'b1_1111_0000;
    localparam ctrl_t CTL_FREEZE = 9'b0_0000_0000;
    localparam ctrl_t CTL_SQUASH = 9'b1_1111_1100;
    localparam ctrl_t CTL_LU     = 9'b0_0111_0100;
    localparam ctrl_t CTL_IMISS  = 9'b0_1111_1000;
    localparam ctrl_t CTL_DRAIN  = 9'b0_0001_1110;
    localparam ctrl_t CTL_RESET  = 9'b0_0000_1111;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare; register 0 never hazards.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_MemRead,
    input  regbits_t ex_Wsel,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    output logic     load_use
);
    assign load_use = ex_MemRead && ex_Wsel != '0 && (ex_Wsel == id_rs || ex_Wsel == id_rt);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the 5-stage pipeline.
// Define PIPE_CTRL_PERF_EN to add saturating stall_cnt/flush_cnt outputs.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        mem_halt,
    input  logic        ex_MemRead,
    input  regbits_t    ex_Wsel,
    input  regbits_t    id_rs,
    input  regbits_t    id_rt,
    input  logic        ex_pcsrc,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exm_en,
    output logic        mwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exm_flush,
    output logic        mwb_flush,
    output logic        halt,
    output ctrl_state_t state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output word_t       stall_cnt,
    output word_t       flush_cnt
`endif
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    ctrl_t         ctl, normal;
    logic          load_use;

    hazard_detect u_hazard (
        .ex_MemRead (ex_MemRead),
        .ex_Wsel    (ex_Wsel),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .load_use   (load_use)
    );

    // Redirect outranks load-use, which outranks an I-cache miss.
    assign normal = ex_pcsrc ? CTL_SQUASH : load_use ? CTL_LU : !ihit ? CTL_IMISS : CTL_RUN;

    always_comb begin
        ctl     = CTL_FREEZE;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (mem_halt) begin
                    ctl     = CTL_DRAIN;
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if ((mem_dREN || mem_dWEN) && !dhit) begin
                    state_d = DWAIT;
                end else begin
                    ctl = normal;
                end
            end
            DWAIT: begin
                ctl     = dhit ? normal : CTL_FREEZE;
                state_d = dhit ? RUN : DWAIT;
            end
            DRAIN: begin
                ctl     = CTL_DRAIN;
                state_d = (cnt_q == CW'(DRAIN_CYCLES - 1)) ? HALTED : DRAIN;
                cnt_d   = (cnt_q == CW'(DRAIN_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
            end
            default: ctl = CTL_FREEZE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign {pc_en, ifid_en, idex_en, exm_en, mwb_en, ifid_flush, idex_flush, exm_flush, mwb_flush} =
        nRST ? ctl : CTL_RESET;
    assign halt    = nRST && state_q == HALTED;
    assign state_o = state_q;

`ifdef PIPE_CTRL_PERF_EN
    word_t stall_q, stall_d, flush_q, flush_d;

    always_comb begin
        stall_d = (!ctl.pc_en && state_q != HALTED && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        flush_d = (ctl == CTL_SQUASH && flush_q != '1) ? flush_q + 1'b1 : flush_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table-driven RUN-state vectors plus reset, D-miss, reset-in-DWAIT and halt sequences.
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    logic CLK = 0, nRST = 0;
    logic ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_MemRead, ex_pcsrc;
    regbits_t ex_Wsel, id_rs, id_rt;
    logic pc_en, ifid_en, idex_en, exm_en, mwb_en;
    logic ifid_flush, idex_flush, exm_flush, mwb_flush, halt;
    ctrl_state_t state_o;
`ifdef PIPE_CTRL_PERF_EN
    word_t stall_cnt, flush_cnt;
`endif

    int checks = 0, failures = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.DRAIN_CYCLES(2)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
        .ex_MemRead(ex_MemRead), .ex_Wsel(ex_Wsel), .id_rs(id_rs), .id_rt(id_rt),
        .ex_pcsrc(ex_pcsrc), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exm_en(exm_en), .mwb_en(mwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exm_flush(exm_flush), .mwb_flush(mwb_flush),
        .halt(halt), .state_o(state_o)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic [5:0] bits;
        regbits_t   wsel, rs, rt;
        logic [8:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [8:0] exp, input logic exp_halt,
                         input ctrl_state_t exp_st);
        logic [8:0] act;
        act = {pc_en, ifid_en, idex_en, exm_en, mwb_en, ifid_flush, idex_flush, exm_flush, mwb_flush};
        checks++;
        if (act !== exp || halt !== exp_halt || state_o !== exp_st) begin
            failures++;
            $display("FAIL %s: got ctl=%b halt=%b state=%0d, want ctl=%b halt=%b state=%0d",
                     name, act, halt, state_o, exp, exp_halt, exp_st);
        end
    endtask

    task automatic drive(input logic [5:0] b, input regbits_t w, input regbits_t s, input regbits_t t);
        {ihit, dhit, mem_dREN, mem_dWEN, ex_MemRead, ex_pcsrc} = b;
        ex_Wsel = w;
        id_rs = s;
        id_rt = t;
        mem_halt = 0;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        // bits = {ihit, dhit, mem_dREN, mem_dWEN, ex_MemRead, ex_pcsrc}
        vecs[0]  = '{"idle",        6'b110000, 5'd0, 5'd0, 5'd0, 9'b1_1111_0000};
        vecs[1]  = '{"imiss",       6'b010000, 5'd0, 5'd0, 5'd0, 9'b0_1111_1000};
        vecs[2]  = '{"lu_rt",       6'b110010, 5'd5, 5'd1, 5'd5, 9'b0_0111_0100};
        vecs[3]  = '{"lu_rs",       6'b110010, 5'd5, 5'd5, 5'd9, 9'b0_0111_0100};
        vecs[4]  = '{"lu_r0",       6'b110010, 5'd0, 5'd0, 5'd0, 9'b1_1111_0000};
        vecs[5]  = '{"lu_nomatch",  6'b110010, 5'd5, 5'd7, 5'd6, 9'b1_1111_0000};
        vecs[6]  = '{"noload",      6'b110000, 5'd5, 5'd5, 5'd5, 9'b1_1111_0000};
        vecs[7]  = '{"br_lu",       6'b110011, 5'd5, 5'd1, 5'd5, 9'b1_1111_1100};
        vecs[8]  = '{"br_imiss",    6'b010001, 5'd0, 5'd0, 5'd0, 9'b1_1111_1100};
        vecs[9]  = '{"lu_imiss",    6'b010010, 5'd3, 5'd3, 5'd0, 9'b0_0111_0100};
        vecs[10] = '{"ld_hit",      6'b111000, 5'd0, 5'd0, 5'd0, 9'b1_1111_0000};
        vecs[11] = '{"st_hit_lu",   6'b110110, 5'd8, 5'd2, 5'd8, 9'b0_0111_0100};

        // Reset with random inputs
        {ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_MemRead, ex_pcsrc} = 7'($urandom);
        ex_Wsel = 5'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
        #3;
        check("reset", 9'b0_0000_1111, 0, RUN);
        drive(6'b110000, 0, 0, 0);
        #1;
        check("reset_inputs_idle", 9'b0_0000_1111, 0, RUN);
        @(negedge CLK);
        nRST = 1;
        #1;
        check("post_reset", 9'b1_1111_0000, 0, RUN);

        foreach (vecs[i]) begin
            drive(vecs[i].bits, vecs[i].wsel, vecs[i].rs, vecs[i].rt);
            #1;
            check(vecs[i].name, vecs[i].exp, 0, RUN);
            tick();
        end

        // Load-use stalls exactly while hazard present
        drive(6'b110010, 5, 1, 5);
        #1;
        check("lu_cycle", 9'b0_0111_0100, 0, RUN);
        tick();
        drive(6'b110000, 0, 0, 0);
        #1;
        check("lu_release", 9'b1_1111_0000, 0, RUN);

        // D-cache miss: 3 frozen cycles then resume
        drive(6'b101000, 0, 0, 0);
        #1;
        check("dmiss_c0", 9'b0_0000_0000, 0, RUN);
        tick();
        check("dmiss_c1", 9'b0_0000_0000, 0, DWAIT);
        tick();
        check("dmiss_c2", 9'b0_0000_0000, 0, DWAIT);
        dhit = 1;
        #1;
        check("dmiss_hit", 9'b1_1111_0000, 0, DWAIT);
        tick();
        drive(6'b110000, 0, 0, 0);
        #1;
        check("dmiss_back_run", 9'b1_1111_0000, 0, RUN);

        // Reset asserted between edges while in DWAIT
        drive(6'b101000, 0, 0, 0);
        tick();
        check("enter_dwait", 9'b0_0000_0000, 0, DWAIT);
        #2;
        nRST = 0;
        #1;
        check("reset_mid_dwait", 9'b0_0000_1111, 0, RUN);
        @(negedge CLK);
        nRST = 1;
        drive(6'b110000, 0, 0, 0);
        #1;
        check("after_dwait_reset", 9'b1_1111_0000, 0, RUN);

        // Halt drain: mwb_en for 3 cycles, then sticky halt
        tick();
        mem_halt = 1;
        #1;
        check("halt_c0", 9'b0_0001_1110, 0, RUN);
        tick();
        mem_halt = 0;
        #1;
        check("drain_c1", 9'b0_0001_1110, 0, DRAIN);
        tick();
        check("drain_c2", 9'b0_0001_1110, 0, DRAIN);
        tick();
        check("halted", 9'b0_0000_0000, 1, HALTED);
        drive(6'b111011, 5, 5, 5);
        for (int i = 0; i < 4; i++) tick();
        check("halted_sticky", 9'b0_0000_0000, 1, HALTED);
        nRST = 0;
        #1;
        check("halt_reset", 9'b0_0000_1111, 0, RUN);

        // Reset mid-DRAIN
        @(negedge CLK);
        nRST = 1;
        drive(6'b110000, 0, 0, 0);
        mem_halt = 1;
        tick();
        mem_halt = 0;
        #1;
        check("drain_enter", 9'b0_0001_1110, 0, DRAIN);
        nRST = 0;
        #1;
        check("reset_mid_drain", 9'b0_0000_1111, 0, RUN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
